inverse_row_normalizer: RTL and testbench
=========================================

// Module: inverse_row_normalizer
// PURPOSE
//   Downstream stage of the 5x5 Gauss-Jordan inverter. The eliminated augmented
//   matrix [D | R] arrives as a row-major stream; left half is diagonal after elimination.
//   Each row's right half is divided by that row's pivot D[r][r].
//   Produces the signed fixed-point inverse, streamed out one element at a time.
// PARAMETERS
//   N     5   matrix order; input row length 2N, output N*N elements
//   W     8   input element width, signed two's complement
//   FRAC  8   fractional bits of quotient; QW = W+FRAC (16)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-high
//   in_data    in   W   augmented-matrix element, row-major, col 0..2N-1
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepts in_data this cycle
//   out_data   out  QW  signed quotient, Q(W).(FRAC)
//   out_row    out  3   row index 0..N-1 of out_data
//   out_col    out  3   inverse column index 0..N-1 (input column N+out_col)
//   out_div0   out  1   pivot of this row was zero; out_data forced 0
//   out_last   out  1   marks element (N-1,N-1), final of matrix
//   out_valid  out  1   out_* valid
//   out_ready  in   1   consumer accepts out_* this cycle
// BEHAVIOUR
// - Reset (async, immediate): state=LOAD, row/col/element counters=0.
//   Outputs out_data/out_row/out_col/out_div0/out_last/out_valid = 0.
//   in_ready = 0 while rst high. Any in-flight row is discarded.
// - Transfers occur only on edges where valid & ready are both high.
//   out_* hold stable while out_valid & !out_ready.
// - FSM LOAD -> SETUP -> DIV -> OUT -> (SETUP | LOAD):
//   LOAD : in_ready=1. Column counter c counts 0..2N-1.
//          c==row: capture pivot. c>=N: buffer R[c-N].
//          Other left-half columns are accepted and ignored.
//          Exits on the edge accepting c=2N-1.
//   SETUP: 1 cycle. Latch sign=sgn(num)^sgn(pivot); form |num|<<FRAC and |pivot|
//          (W+1-bit unsigned, so -128 -> 128). Clear remainder.
//   DIV  : exactly QW cycles of restoring division, one quotient bit per cycle, MSB first.
//          Remainder W+1 bits. Runs even if pivot==0, so timing is fixed.
//   OUT  : out_valid=1. On handshake: if col<N-1 then col++, go SETUP.
//          Otherwise col=0; if row<N-1 then row++, go LOAD; otherwise row=0, go LOAD.
// - Latency: first out_valid is QW+2 edges after the row's final input handshake (18).
//   Each later element of the row is QW+2 edges after the previous output handshake.
// - Arithmetic: q = trunc_toward_zero((num*2^FRAC)/pivot), sign applied after magnitude divide.
//   Saturate to [-2^(QW-1), 2^(QW-1)-1]. Only case: num=-128, pivot=-1 -> 0x7FFF.
// - pivot==0: out_div0=1 and out_data=0 for all N elements of that row.
//   Later rows are unaffected; out_div0 is evaluated per row.
// - out_last=1 only with out_row=N-1, out_col=N-1.
//   After that handshake the next input is row 0 of a new matrix.
// - in_ready=0 in SETUP/DIV/OUT; input is never buffered beyond the current row.
// - out_valid never drops without a handshake, except on rst.
// TESTING
// 1 Input [I|I], pivots 1 -> 25 outputs: 0x0100 when out_row==out_col, else 0x0000.
//   out_last only on the 25th; 18-edge first latency.
// 2 Row pivot 4, R=[1,-1,2,-128,127] -> 0x0040, 0xFFC0, 0x0080, 0xE000, 0x1FC0.
// 3 Pivot -3, num 1 -> 0xFFAB. Pivot -1, num -128 -> 0x7FFF (sat).
//   Pivot 1, num -128 -> 0x8000.
// 4 Row 2 pivot 0 -> row 2: out_div0=1, out_data=0 x5.
//   Rows 0,1,3,4 correct with out_div0=0.
// 5 Hold out_ready low 10 cycles mid-row -> out_* stable, in_ready=0, no element lost or duplicated.
// 6 Assert rst during DIV of row 1 -> all outputs 0 at once.
//   After release in_ready=1; a fresh matrix is output from row 0 col 0.

Source files
------------

// File: rtl/inverse_row_normalizer.sv
// -----------------------------------------------------------------------------
// inverse_row_normalizer
//   Back end of the 5x5 Gauss-Jordan inverter. The eliminated augmented matrix
//   [D | R] arrives row-major, one element per handshake. For each row the
//   pivot D[r][r] is captured and the right half R[r][*] is buffered. Each
//   buffered element is then divided by the pivot with a bit-serial restoring
//   divider. The signed Q(W).(FRAC) quotients are streamed out one per
//   handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_data    augmented-matrix element (signed, W bits), columns 0..2N-1
//   in_valid   in_data valid
//   in_ready   block accepts in_data (only while loading a row)
//   out_data   signed quotient, QW = W+FRAC bits
//   out_row    row index of out_data
//   out_col    inverse column index of out_data (input column N+out_col)
//   out_div0   the row's pivot was zero; out_data forced to 0
//   out_last   final element (N-1, N-1) of the matrix
//   out_valid  out_* valid
//   out_ready  consumer accepts out_*
// -----------------------------------------------------------------------------
module inverse_row_normalizer #(
  parameter int N    = 5,
  parameter int W    = 8,
  parameter int FRAC = 8,
  parameter int QW   = W + FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [QW-1:0] out_data,
  output logic [2:0]    out_row,
  output logic [2:0]    out_col,
  output logic          out_div0,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = $clog2(2 * N);  // input column counter width
  localparam int IW = $clog2(N);      // row-buffer index width
  localparam int BW = $clog2(QW);     // divider step counter width

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DIV   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Magnitude of a signed W-bit value as a W+1-bit unsigned (-2^(W-1) maps to 2^(W-1)).
  function automatic logic [W:0] mag_of(input logic [W-1:0] x);
    logic [W:0] ext;
    ext = {x[W-1], x};
    if (x[W-1]) begin
      mag_of = (~ext) + {{W{1'b0}}, 1'b1};
    end else begin
      mag_of = ext;
    end
  endfunction

  // Apply the sign to the unsigned quotient. Only a positive 2^(QW-1) can
  // overflow, and it saturates to the largest positive code.
  function automatic logic [QW-1:0] finalize(input logic [QW-1:0] mag,
                                             input logic          neg,
                                             input logic          zero_div);
    logic [QW-1:0] res;
    if (zero_div) begin
      res = '0;
    end else if (neg) begin
      res = (~mag) + {{(QW-1){1'b0}}, 1'b1};
    end else if (mag[QW-1]) begin
      res = {1'b0, {(QW-1){1'b1}}};
    end else begin
      res = mag;
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]    pivot_q, pivot_d;
  logic [W-1:0]    rbuf_q [N];
  logic [W-1:0]    rbuf_d [N];
  logic            sign_q, sign_d;
  logic [W:0]      divisor_q, divisor_d;
  logic [W:0]      rem_q, rem_d;
  logic [QW-1:0]   dq_q, dq_d;          // dividend shifts out the top, quotient shifts in the bottom
  logic            in_ready_q, in_ready_d;
  logic [QW-1:0]   out_data_q, out_data_d;
  logic [2:0]      out_row_q, out_row_d;
  logic [2:0]      out_col_q, out_col_d;
  logic            out_div0_q, out_div0_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    num_s;
  logic [W:0]      num_mag_s;
  logic [IW-1:0]   rb_idx_s;
  logic [W+1:0]    shifted_s;
  logic            qbit_s;
  logic [W:0]      diff_s;
  logic [QW-1:0]   dq_next_s;
  logic            in_hs_s;

  // Next-state, datapath and output-register logic for the row pipeline.
  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    row_d       = row_q;
    col_d       = col_q;
    bit_cnt_d   = bit_cnt_q;
    pivot_d     = pivot_q;
    rbuf_d      = rbuf_q;
    sign_d      = sign_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_div0_d  = out_div0_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    in_hs_s   = in_valid && in_ready_q;
    num_s     = rbuf_q[col_q];
    num_mag_s = mag_of(num_s);
    rb_idx_s  = IW'(in_col_q - CW'(N));

    // One restoring step: the remainder is always below the divisor, so when
    // the trial succeeds the difference fits in W+1 bits.
    shifted_s = {rem_q, dq_q[QW-1]};
    qbit_s    = (shifted_s >= {1'b0, divisor_q});
    diff_s    = shifted_s[W:0] - divisor_q;
    dq_next_s = {dq_q[QW-2:0], qbit_s};

    case (state_q)
      ST_LOAD: begin
        if (in_hs_s) begin
          if (in_col_q == CW'(row_q)) begin
            pivot_d = in_data;
          end else begin
            pivot_d = pivot_q;
          end
          if (in_col_q >= CW'(N)) begin
            rbuf_d[rb_idx_s] = in_data;
          end else begin
            rbuf_d = rbuf_q;
          end
          if (in_col_q == CW'(2 * N - 1)) begin
            in_col_d = '0;
            state_d  = ST_SETUP;
          end else begin
            in_col_d = in_col_q + CW'(1);
            state_d  = ST_LOAD;
          end
        end else begin
          in_col_d = in_col_q;
        end
      end

      ST_SETUP: begin
        sign_d    = num_s[W-1] ^ pivot_q[W-1];
        divisor_d = mag_of(pivot_q);
        dq_d      = QW'({num_mag_s, {FRAC{1'b0}}});
        rem_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_DIV;
      end

      ST_DIV: begin
        rem_d     = qbit_s ? diff_s : shifted_s[W:0];
        dq_d      = dq_next_s;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(QW - 1)) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_data_d  = finalize(dq_next_s, sign_q, (pivot_q == '0));
          out_row_d   = row_q;
          out_col_d   = col_q;
          out_div0_d  = (pivot_q == '0);
          out_last_d  = (row_q == 3'(N - 1)) && (col_q == 3'(N - 1));
        end else begin
          state_d = ST_DIV;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (col_q < 3'(N - 1)) begin
            col_d   = col_q + 3'd1;
            state_d = ST_SETUP;
          end else begin
            col_d   = '0;
            state_d = ST_LOAD;
            if (row_q < 3'(N - 1)) begin
              row_d = row_q + 3'd1;
            end else begin
              row_d = '0;
            end
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Input is only taken while a row is being loaded.
    in_ready_d = (state_d == ST_LOAD);
  end

  // State and datapath registers; reset discards any in-flight row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      in_col_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      bit_cnt_q   <= '0;
      pivot_q     <= '0;
      for (int i = 0; i < N; i++) begin
        rbuf_q[i] <= '0;
      end
      sign_q      <= 1'b0;
      divisor_q   <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_div0_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      row_q       <= row_d;
      col_q       <= col_d;
      bit_cnt_q   <= bit_cnt_d;
      pivot_q     <= pivot_d;
      rbuf_q      <= rbuf_d;
      sign_q      <= sign_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_div0_q  <= out_div0_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_div0  = out_div0_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inverse_row_normalizer.sv
// -----------------------------------------------------------------------------
// tb_inverse_row_normalizer
//   Directed bench for inverse_row_normalizer. Matrices are described row by
//   row with hand-computed expected quotients; every output element is checked
//   for data, row, column, div0 and last flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inverse_row_normalizer;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int FRAC = 8;
  localparam int QW   = W + FRAC;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] out_data;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic          out_div0;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_in  [0:4][0:9];
  logic [15:0] m_exp [0:4][0:4];
  logic        m_z   [0:4];

  always #5 clk = ~clk;

  inverse_row_normalizer #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_div0  (out_div0),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Identity matrix [I | I]: every quotient is 1.0 (0x0100) on the diagonal.
  task automatic set_identity();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < 2 * N; c++) begin
        m_in[r][c] = ((c == r) || (c == r + N)) ? 8'h01 : 8'h00;
      end
      for (int k = 0; k < N; k++) begin
        m_exp[r][k] = (k == r) ? 16'h0100 : 16'h0000;
      end
      m_z[r] = 1'b0;
    end
  endtask

  // One row: pivot p on the diagonal, junk 0x5A elsewhere in the left half
  // (must be ignored), right half rv (element 0 in the top byte), expected ev.
  task automatic set_row(input int r, input logic [7:0] p, input logic [39:0] rv,
                         input logic [79:0] ev, input logic z);
    for (int c = 0; c < N; c++) begin
      m_in[r][c] = (c == r) ? p : 8'h5A;
    end
    for (int k = 0; k < N; k++) begin
      m_in[r][N + k] = rv[8 * (N - 1 - k) +: 8];
      m_exp[r][k]    = ev[16 * (N - 1 - k) +: 16];
    end
    m_z[r] = z;
  endtask

  task automatic send_elem(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_check(input int r, input int k, input logic [15:0] ed, input logic ez,
                            input bit stall, output int waited);
    logic el;
    el        = (r == N - 1) && (k == N - 1);
    out_ready = !stall;
    waited    = 0;
    while (!out_valid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("out_valid", 32'(out_valid), 32'd1);
    check_eq("out_data",  32'(out_data),  32'(ed));
    check_eq("out_row",   32'(out_row),   32'(r));
    check_eq("out_col",   32'(out_col),   32'(k));
    check_eq("out_div0",  32'(out_div0),  32'(ez));
    check_eq("out_last",  32'(out_last),  32'(el));
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check_eq("stall_valid",    32'(out_valid), 32'd1);
        check_eq("stall_data",     32'(out_data),  32'(ed));
        check_eq("stall_row",      32'(out_row),   32'(r));
        check_eq("stall_col",      32'(out_col),   32'(k));
        check_eq("stall_in_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_row(input int r, input int stall_k, input bit lat_chk);
    int waited;
    for (int c = 0; c < 2 * N; c++) begin
      send_elem(m_in[r][c]);
    end
    for (int k = 0; k < N; k++) begin
      recv_check(r, k, m_exp[r][k], m_z[r], (k == stall_k), waited);
      // waited counts edges after the handshake edge; +1 includes that edge.
      if (lat_chk && k == 0) check_eq("first_latency", 32'(waited + 1), 32'(QW + 2));
      if (lat_chk && k == 1) check_eq("next_latency",  32'(waited + 1), 32'(QW + 2));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"},    32'(out_valid), 32'd0);
    check_eq({tag, "_data"},     32'(out_data),  32'd0);
    check_eq({tag, "_row"},      32'(out_row),   32'd0);
    check_eq({tag, "_col"},      32'(out_col),   32'd0);
    check_eq({tag, "_div0"},     32'(out_div0),  32'd0);
    check_eq({tag, "_last"},     32'(out_last),  32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Identity matrix, with first- and next-element latency.
    set_identity();
    for (int r = 0; r < N; r++) run_row(r, -1, (r == 0));

    // Signed arithmetic, truncation toward zero and saturation.
    set_identity();
    set_row(0, 8'h04, {8'h01, 8'hFF, 8'h02, 8'h80, 8'h7F},
            {16'h0040, 16'hFFC0, 16'h0080, 16'hE000, 16'h1FC0}, 1'b0);
    set_row(1, 8'hFD, {8'h01, 8'h00, 8'h00, 8'h00, 8'h00},
            {16'hFFAB, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0);
    set_row(2, 8'hFF, {8'h80, 8'h01, 8'h00, 8'h00, 8'h00},
            {16'h7FFF, 16'hFF00, 16'h0000, 16'h0000, 16'h0000}, 1'b0);
    set_row(3, 8'h01, {8'h80, 8'h00, 8'h00, 8'h00, 8'h05},
            {16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0500}, 1'b0);
    set_row(4, 8'h02, {8'h00, 8'h00, 8'h00, 8'h00, 8'h03},
            {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0180}, 1'b0);
    for (int r = 0; r < N; r++) run_row(r, -1, 1'b0);

    // Zero pivot on row 2 only; back-pressure on row 1 element 2.
    set_identity();
    set_row(2, 8'h00, {8'h05, 8'h05, 8'h05, 8'h05, 8'h05},
            {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b1);
    for (int r = 0; r < N; r++) run_row(r, (r == 1) ? 2 : -1, 1'b0);

    // Reset while row 1 is dividing, then a fresh matrix from row 0.
    set_identity();
    set_row(0, 8'h04, {8'h01, 8'hFF, 8'h02, 8'h80, 8'h7F},
            {16'h0040, 16'hFFC0, 16'h0080, 16'hE000, 16'h1FC0}, 1'b0);
    run_row(0, -1, 1'b0);
    for (int c = 0; c < 2 * N; c++) send_elem(m_in[1][c]);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
    set_identity();
    for (int r = 0; r < N; r++) run_row(r, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
